// File: rtl/order_pkg.sv
// order_pkg: shared types and widths for the order timer and its interface.
//   ORDER_TIME_W : width of the remaining-steps countdown
//   SCORE_W      : width of the served-orders score
//   MAX_STRIKES  : expiries that end the game (strike build only)
//   state_e      : order FSM states; StOver exists only when ORDER_TIMER_STRIKES_EN is defined
package order_pkg;

    localparam int unsigned ORDER_TIME_W = 5;
    localparam int unsigned SCORE_W      = 8;
    localparam int unsigned MAX_STRIKES  = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGap    = 2'd1,
        StActive = 2'd2
`ifdef ORDER_TIMER_STRIKES_EN
        , StOver = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/order_timer_if.sv
// order_timer_if: game-control pulses in, order/score status out.
//   master : drives start/stop/serve pulses, observes status
//   slave  : the order timer itself
interface order_timer_if;
    import order_pkg::*;

    logic                    start_in;
    logic                    stop_in;
    logic                    serve_in;
    logic                    order_out;
    logic [ORDER_TIME_W-1:0] order_time_out;
    logic [SCORE_W-1:0]      score_out;
    logic                    served_out;
    logic                    expired_out;
    logic                    game_over_out;

    modport master (
        output start_in, stop_in, serve_in,
        input  order_out, order_time_out, score_out, served_out, expired_out, game_over_out
    );

    modport slave (
        input  start_in, stop_in, serve_in,
        output order_out, order_time_out, score_out, served_out, expired_out, game_over_out
    );

endinterface

// File: rtl/step_prescaler.sv
// step_prescaler: divides the clock into step ticks for game timers.
//   clk_i     : clock
//   rst_n_i   : synchronous active-low reset
//   restart_i : clear the count; the next tick comes STEP_CYCLES clocks later
//   tick_o    : high for one cycle every STEP_CYCLES clocks
module step_prescaler #(
    parameter int unsigned STEP_CYCLES = 25_175_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned     CntW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/order_timer.sv
// order_timer: kitchen-game order sequencer. Opens an order after a gap, counts its
// remaining time down in steps, and scores serves or flags expiries.
//   pixel_clk_in : clock
//   rst_n_in     : synchronous active-low reset
//   bus          : order_timer_if.slave (start/stop/serve in; order, time, score, pulses out)
// Optional: define ORDER_TIMER_STRIKES_EN to end the game after MAX_STRIKES expiries.
module order_timer
    import order_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 25_175_000,
    parameter int unsigned ORDER_STEPS = 31,
    parameter int unsigned GAP_STEPS   = 3
) (
    input  logic         pixel_clk_in,
    input  logic         rst_n_in,
    order_timer_if.slave bus
);

    localparam logic [ORDER_TIME_W-1:0] OrderInit = ORDER_TIME_W'(ORDER_STEPS);
    localparam logic [4:0]              GapLast   = 5'(GAP_STEPS - 1);

    state_e                  state_q, state_d;
    logic [4:0]              gap_cnt_q, gap_cnt_d;
    logic                    order_q, order_d;
    logic [ORDER_TIME_W-1:0] time_q, time_d;
    logic [SCORE_W-1:0]      score_q, score_d;
    logic                    served_q, served_d;
    logic                    expired_q, expired_d;
    logic                    step_tick;
    logic                    restart;

`ifdef ORDER_TIMER_STRIKES_EN
    localparam logic [1:0] StrikeLast = 2'(MAX_STRIKES - 1);
    logic [1:0] strikes_q, strikes_d;
    logic       over_q, over_d;
`endif

    // Every state entry restarts the step timer so the first step is full length.
    step_prescaler #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_prescaler (
        .clk_i    (pixel_clk_in),
        .rst_n_i  (rst_n_in),
        .restart_i(restart),
        .tick_o   (step_tick)
    );

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        order_d   = order_q;
        time_d    = time_q;
        score_d   = score_q;
        served_d  = 1'b0;
        expired_d = 1'b0;
`ifdef ORDER_TIMER_STRIKES_EN
        strikes_d = strikes_q;
        over_d    = over_q;
`endif
        if (bus.stop_in) begin
            state_d = StIdle;
            order_d = 1'b0;
            time_d  = '0;
`ifdef ORDER_TIMER_STRIKES_EN
            over_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start_in) begin
                        score_d = '0;
                        state_d = StGap;
`ifdef ORDER_TIMER_STRIKES_EN
                        strikes_d = '0;
`endif
                    end
                end
                StGap: begin
                    if (step_tick) begin
                        if (gap_cnt_q == GapLast) begin
                            state_d = StActive;
                            order_d = 1'b1;
                            time_d  = OrderInit;
                        end else begin
                            gap_cnt_d = gap_cnt_q + 5'd1;
                        end
                    end
                end
                StActive: begin
                    // A serve on the expiring tick still counts as a serve.
                    if (bus.serve_in) begin
                        served_d = 1'b1;
                        if (score_q != '1) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        order_d = 1'b0;
                        time_d  = '0;
                        state_d = StGap;
                    end else if (step_tick) begin
                        if (time_q != '0) begin
                            time_d = time_q - ORDER_TIME_W'(1);
                        end else begin
                            expired_d = 1'b1;
                            order_d   = 1'b0;
                            state_d   = StGap;
`ifdef ORDER_TIMER_STRIKES_EN
                            strikes_d = strikes_q + 2'd1;
                            if (strikes_q == StrikeLast) begin
                                state_d = StOver;
                                over_d  = 1'b1;
                            end
`endif
                        end
                    end
                end
`ifdef ORDER_TIMER_STRIKES_EN
                StOver: begin
                    if (bus.start_in) begin
                        strikes_d = '0;
                        over_d    = 1'b0;
                        score_d   = '0;
                        state_d   = StGap;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
        restart = (state_d != state_q);
        if (restart) begin
            gap_cnt_d = '0;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            order_q   <= 1'b0;
            time_q    <= '0;
            score_q   <= '0;
            served_q  <= 1'b0;
            expired_q <= 1'b0;
`ifdef ORDER_TIMER_STRIKES_EN
            strikes_q <= '0;
            over_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            order_q   <= order_d;
            time_q    <= time_d;
            score_q   <= score_d;
            served_q  <= served_d;
            expired_q <= expired_d;
`ifdef ORDER_TIMER_STRIKES_EN
            strikes_q <= strikes_d;
            over_q    <= over_d;
`endif
        end
    end

    assign bus.order_out      = order_q;
    assign bus.order_time_out = time_q;
    assign bus.score_out      = score_q;
    assign bus.served_out     = served_q;
    assign bus.expired_out    = expired_q;
`ifdef ORDER_TIMER_STRIKES_EN
    assign bus.game_over_out  = over_q;
`else
    assign bus.game_over_out  = 1'b0;
`endif

endmodule

// File: tb/tb_order_timer.sv
// tb_order_timer: directed scenarios plus a randomized run against a behavioural model.
module tb_order_timer;

    localparam int unsigned STEP = 4;
    localparam int unsigned ORD  = 5;
    localparam int unsigned GAP  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    order_timer_if bus();

    order_timer #(
        .STEP_CYCLES(STEP),
        .ORDER_STEPS(ORD),
        .GAP_STEPS  (GAP)
    ) dut (
        .pixel_clk_in(clk),
        .rst_n_in    (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model: phase 0 idle, 1 gap, 2 active, 3 over.
    int m_phase, m_elapsed, m_gap_ticks, m_time, m_score, m_strikes;
    bit m_order, m_served, m_expired, m_over;

    task automatic model_step(input bit rs, input bit st, input bit sp, input bit sv);
        int  nxt;
        bit  tick;
        m_served  = 1'b0;
        m_expired = 1'b0;
        if (!rs) begin
            m_phase = 0; m_elapsed = 0; m_gap_ticks = 0; m_time = 0;
            m_score = 0; m_strikes = 0; m_order = 1'b0; m_over = 1'b0;
            return;
        end
        // A step ends every STEP clocks counted from the last phase entry.
        tick = ((m_elapsed + 1) % STEP) == 0;
        nxt  = m_phase;
        if (sp) begin
            nxt = 0; m_order = 1'b0; m_time = 0; m_over = 1'b0;
        end else begin
            case (m_phase)
                0: if (st) begin m_score = 0; m_strikes = 0; nxt = 1; end
                1: if (tick) begin
                    m_gap_ticks++;
                    if (m_gap_ticks == GAP) begin nxt = 2; m_order = 1'b1; m_time = ORD; end
                end
                2: if (sv) begin
                    m_served = 1'b1;
                    if (m_score < 255) m_score++;
                    m_order = 1'b0; m_time = 0; nxt = 1;
                end else if (tick) begin
                    if (m_time > 0) m_time--;
                    else begin
                        m_expired = 1'b1; m_order = 1'b0; nxt = 1;
`ifdef ORDER_TIMER_STRIKES_EN
                        m_strikes++;
                        if (m_strikes == 3) begin nxt = 3; m_over = 1'b1; end
`endif
                    end
                end
                3: if (st) begin m_strikes = 0; m_over = 1'b0; m_score = 0; nxt = 1; end
                default: nxt = 0;
            endcase
        end
        if (nxt != m_phase) begin m_elapsed = 0; m_gap_ticks = 0; end
        else m_elapsed++;
        m_phase = nxt;
    endtask

    // One clock: drive inputs on the falling edge, advance the model on the rising edge.
    task automatic step(input bit rs, input bit st, input bit sp, input bit sv);
        @(negedge clk);
        rst_n        = rs;
        bus.start_in = st;
        bus.stop_in  = sp;
        bus.serve_in = sv;
        @(posedge clk);
        model_step(rs, st, sp, sv);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        vectors++;
        if ({bus.order_out, bus.order_time_out, bus.score_out, bus.served_out,
             bus.expired_out, bus.game_over_out} !== 17'd0) begin
            errors++;
            $display("FAIL reset: outputs=%h want 0", {bus.order_out, bus.order_time_out,
                     bus.score_out, bus.served_out, bus.expired_out, bus.game_over_out});
        end
    endtask

    task automatic test_open_and_expire();
        idle(1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            idle(1);
            vectors++;
            if (k < 8 && bus.order_out !== 1'b0) begin
                errors++;
                $display("FAIL open_early: clk %0d order=%b want 0", k, bus.order_out);
            end
        end
        vectors++;
        if (bus.order_out !== 1'b1 || bus.order_time_out !== 5'd5) begin
            errors++;
            $display("FAIL open: order=%b time=%0d want 1/5", bus.order_out, bus.order_time_out);
        end
        for (int v = 4; v >= 0; v--) begin
            idle(3);
            vectors++;
            if (bus.order_time_out !== 5'(v + 1)) begin
                errors++;
                $display("FAIL countdown_hold: time=%0d want %0d", bus.order_time_out, v + 1);
            end
            idle(1);
            vectors++;
            if (bus.order_time_out !== 5'(v) || bus.order_out !== 1'b1) begin
                errors++;
                $display("FAIL countdown: time=%0d order=%b want %0d/1", bus.order_time_out,
                         bus.order_out, v);
            end
        end
        idle(3);
        vectors++;
        if (bus.expired_out !== 1'b0 || bus.order_out !== 1'b1) begin
            errors++;
            $display("FAIL expire_early: exp=%b order=%b want 0/1", bus.expired_out, bus.order_out);
        end
        idle(1);
        vectors++;
        if (bus.expired_out !== 1'b1 || bus.order_out !== 1'b0) begin
            errors++;
            $display("FAIL expire: exp=%b order=%b want 1/0", bus.expired_out, bus.order_out);
        end
        idle(1);
        vectors++;
        if (bus.expired_out !== 1'b0) begin
            errors++;
            $display("FAIL expire_pulse: exp=%b want 0", bus.expired_out);
        end
    endtask

    task automatic test_serve();
        idle(7);
        idle(8);
        vectors++;
        if (bus.order_out !== 1'b1 || bus.order_time_out !== 5'd3) begin
            errors++;
            $display("FAIL serve_setup: order=%b time=%0d want 1/3", bus.order_out,
                     bus.order_time_out);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.served_out !== 1'b1 || bus.score_out !== 8'd1 || bus.order_out !== 1'b0 ||
            bus.order_time_out !== 5'd0) begin
            errors++;
            $display("FAIL serve: srv=%b score=%0d order=%b time=%0d want 1/1/0/0",
                     bus.served_out, bus.score_out, bus.order_out, bus.order_time_out);
        end
        idle(7);
        vectors++;
        if (bus.order_out !== 1'b0 || bus.served_out !== 1'b0) begin
            errors++;
            $display("FAIL reopen_early: order=%b srv=%b want 0/0", bus.order_out, bus.served_out);
        end
        idle(1);
        vectors++;
        if (bus.order_out !== 1'b1 || bus.order_time_out !== 5'd5) begin
            errors++;
            $display("FAIL reopen: order=%b time=%0d want 1/5", bus.order_out, bus.order_time_out);
        end
    endtask

    task automatic test_serve_on_expiry();
        idle(23);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.served_out !== 1'b1 || bus.expired_out !== 1'b0 || bus.score_out !== 8'd2) begin
            errors++;
            $display("FAIL serve_on_expiry: srv=%b exp=%b score=%0d want 1/0/2",
                     bus.served_out, bus.expired_out, bus.score_out);
        end
        idle(1);
        vectors++;
        if (bus.expired_out !== 1'b0) begin
            errors++;
            $display("FAIL serve_on_expiry_late: exp=%b want 0", bus.expired_out);
        end
        idle(7);
        for (int j = 0; j < 253; j++) begin
            idle(8);
            step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        vectors++;
        if (bus.score_out !== 8'd255) begin
            errors++;
            $display("FAIL score_255: score=%0d want 255", bus.score_out);
        end
        idle(8);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.score_out !== 8'd255 || bus.served_out !== 1'b1) begin
            errors++;
            $display("FAIL score_sat: score=%0d srv=%b want 255/1", bus.score_out, bus.served_out);
        end
    endtask

    task automatic test_reset_and_stop();
        idle(10);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({bus.order_out, bus.order_time_out, bus.score_out, bus.served_out,
             bus.expired_out, bus.game_over_out} !== 17'd0) begin
            errors++;
            $display("FAIL reset_active: outputs=%h want 0", {bus.order_out, bus.order_time_out,
                     bus.score_out, bus.served_out, bus.expired_out, bus.game_over_out});
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.served_out !== 1'b0 || bus.score_out !== 8'd0) begin
            errors++;
            $display("FAIL idle_serve: srv=%b score=%0d want 0/0", bus.served_out, bus.score_out);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(8);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (bus.order_out !== 1'b0 || bus.order_time_out !== 5'd0 || bus.score_out !== 8'd1 ||
            bus.served_out !== 1'b0) begin
            errors++;
            $display("FAIL stop_gap: order=%b time=%0d score=%0d srv=%b want 0/0/1/0",
                     bus.order_out, bus.order_time_out, bus.score_out, bus.served_out);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(12);
        vectors++;
        if (bus.order_out !== 1'b0 || bus.score_out !== 8'd1) begin
            errors++;
            $display("FAIL stop_idle: order=%b score=%0d want 0/1", bus.order_out, bus.score_out);
        end
    endtask

    task automatic test_strikes();
        bit opened;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(8);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int e = 0; e < 3; e++) begin
            idle(32);
            vectors++;
            if (bus.expired_out !== 1'b1 || bus.order_out !== 1'b0) begin
                errors++;
                $display("FAIL strike_expire %0d: exp=%b order=%b want 1/0", e, bus.expired_out,
                         bus.order_out);
            end
        end
`ifdef ORDER_TIMER_STRIKES_EN
        opened = 1'b0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (bus.order_out !== 1'b0) opened = 1'b1;
        end
        vectors++;
        if (bus.game_over_out !== 1'b1 || opened) begin
            errors++;
            $display("FAIL game_over: over=%b order_seen=%b want 1/0", bus.game_over_out, opened);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.score_out !== 8'd0 || bus.game_over_out !== 1'b0) begin
            errors++;
            $display("FAIL restart: score=%0d over=%b want 0/0", bus.score_out, bus.game_over_out);
        end
`else
        opened = 1'b0;
        vectors++;
        if (bus.game_over_out !== 1'b0 || bus.score_out !== 8'd1 || opened) begin
            errors++;
            $display("FAIL no_strikes: over=%b score=%0d want 0/1", bus.game_over_out,
                     bus.score_out);
        end
`endif
        idle(8);
        vectors++;
        if (bus.order_out !== 1'b1 || bus.order_time_out !== 5'd5) begin
            errors++;
            $display("FAIL strike_reopen: order=%b time=%0d want 1/5", bus.order_out,
                     bus.order_time_out);
        end
    endtask

    task automatic test_random(input int n);
        int srv_rate;
        srv_rate = 8;
        for (int i = 0; i < n; i++) begin
            bit rs, st, sp, sv;
            if (i % 200 == 0) srv_rate = $urandom_range(3, 60);
            rs = ($urandom_range(0, 299) != 0);
            st = ($urandom_range(0, 29) == 0);
            sp = ($urandom_range(0, 149) == 0);
            sv = ($urandom_range(0, srv_rate) == 0);
            step(rs, st, sp, sv);
            vectors++;
            if (bus.order_out !== m_order || bus.order_time_out !== 5'(m_time) ||
                bus.score_out !== 8'(m_score) || bus.served_out !== m_served ||
                bus.expired_out !== m_expired || bus.game_over_out !== m_over) begin
                errors++;
                $display("FAIL random cyc %0d: got o=%b t=%0d s=%0d srv=%b exp=%b ov=%b want o=%b t=%0d s=%0d srv=%b exp=%b ov=%b",
                         i, bus.order_out, bus.order_time_out, bus.score_out, bus.served_out,
                         bus.expired_out, bus.game_over_out, m_order, m_time, m_score,
                         m_served, m_expired, m_over);
            end
        end
    endtask

    initial begin
        bus.start_in = 1'b0;
        bus.stop_in  = 1'b0;
        bus.serve_in = 1'b0;
        test_reset();
        test_open_and_expire();
        test_serve();
        test_serve_on_expiry();
        test_reset_and_stop();
        test_strikes();
        test_random(4000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/order_timer.md
ORDER_TIMER -- requirements
Module: order_timer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 25_175_000, pixel clocks per countdown step (1 s at 25.175 MHz).
REQ-002 SHALL have parameter ORDER_STEPS, default 31, initial order_time of a new order (legal range 1..31).
REQ-003 SHALL have parameter GAP_STEPS, default 3, steps between one order ending and the next one starting (legal range 1..31).
REQ-004 pixel_clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n_in  input  1  synchronous, active-low reset.
REQ-006 start_in  input  1  single-cycle pulse; starts a game.
REQ-007 stop_in  input  1  single-cycle pulse; aborts the game.
REQ-008 serve_in  input  1  single-cycle pulse; the player delivered the ordered dish.
REQ-009 order_out  output  1  an order is open; drives the display's order input.
REQ-010 order_time_out  output  5  remaining steps of the open order; drives the display's countdown bar width.
REQ-011 score_out  output  8  orders served this game.
REQ-012 served_out  output  1  one-cycle pulse on an accepted serve.
REQ-013 expired_out  output  1  one-cycle pulse when an order times out.
REQ-014 game_over_out  output  1  game has ended on strikes (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, GAP, ACTIVE, OVER; all outputs SHALL be registered.
REQ-016 IDLE: start_in SHALL clear score_out and enter GAP; serve_in is ignored.
REQ-017 On every entry to GAP or ACTIVE, the step prescaler SHALL restart, so the first step lasts a full STEP_CYCLES.
REQ-018 A step tick SHALL occur on the STEP_CYCLES-th clock after the prescaler restarts, and every STEP_CYCLES clocks after that.
REQ-019 GAP: after GAP_STEPS ticks the FSM SHALL enter ACTIVE; on the same edge order_out SHALL go 1 and order_time_out SHALL be set to ORDER_STEPS.
REQ-020 ACTIVE: each tick SHALL decrement order_time_out while it is nonzero.
REQ-021 ACTIVE: a tick while order_time_out==0 SHALL pulse expired_out, clear order_out and enter GAP.
REQ-022 ACTIVE: serve_in SHALL pulse served_out, increment score_out (saturating at 255), clear order_out, zero order_time_out and enter GAP.
REQ-023 serve_in and the expiring tick on the same cycle SHALL count as a serve; expired_out SHALL stay 0.
REQ-024 serve_in outside ACTIVE SHALL have no effect; start_in outside IDLE SHALL have no effect.
REQ-025 stop_in in any state SHALL enter IDLE, clear order_out and order_time_out, and keep score_out; stop_in SHALL override start_in and serve_in on the same cycle.
REQ-026 Pulse outputs SHALL be high for exactly one cycle, registered on the edge where the FSM transitions.

Reset
REQ-027 While rst_n_in==0 at a clock edge, the block SHALL enter IDLE, zero every output and counter, and take precedence over all other inputs, including mid-order.

Configuration
REQ-028 With ORDER_TIMER_STRIKES_EN defined, a 2-bit strike counter SHALL increment on each expiry; the third expiry SHALL enter OVER, assert game_over_out and hold order_out=0; start_in from OVER SHALL clear the strikes, game_over_out and score and enter GAP; stop_in from OVER SHALL enter IDLE.
REQ-029 Without ORDER_TIMER_STRIKES_EN, OVER and the strike counter SHALL not exist, game_over_out SHALL be tied to 0, and expiries SHALL only pulse expired_out.

Structure
REQ-030 Shared package order_pkg SHALL hold the FSM state enum, ORDER_TIME_W=5, SCORE_W=8 and MAX_STRIKES=3.
REQ-031 The prescaler SHALL be a sub-module step_prescaler (inputs clk, rst_n, restart; output tick), reused by other game timers.

Verification (STEP_CYCLES=4, ORDER_STEPS=5, GAP_STEPS=2)
REQ-032 Reset, start_in -> order_out rises exactly 8 clocks later with order_time_out=5, then reads 4,3,2,1,0 every 4 clocks.
REQ-033 No serve -> expired_out pulses 4 clocks after order_time_out reaches 0, and order_out falls on that edge.
REQ-034 serve_in while order_time_out=3 -> served_out pulse, score_out 0->1, order_out=0, next order opens 8 clocks later.
REQ-035 serve_in on the expiring tick -> score_out increments, expired_out stays 0; score at 255 plus a serve -> stays 255.
REQ-036 rst_n_in=0 mid-ACTIVE, or stop_in mid-GAP -> next cycle IDLE with all outputs 0 (stop_in keeps score_out), then serve_in -> no change.
REQ-037 With ORDER_TIMER_STRIKES_EN: three expiries -> game_over_out=1 and order_out stays 0; start_in -> score 0, a new order after 8 clocks.
